key_debounce_array: RTL
=======================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter N_KEYS, default 4: number of independent key channels, range 1..32.
REQ-003 Parameter DEBOUNCE_CYCLES, default 2500000 (50 ms at 50 MHz): stable cycles required to accept a level change, minimum 2.
REQ-004 Parameter LONG_PRESS_CYCLES, default 50000000 (1 s): cycles in DOWN before long_press fires; must be greater than DEBOUNCE_CYCLES.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means pressed = key_in 0; 0 means pressed = key_in 1.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 key_in  input  N_KEYS  raw asynchronous key pins, one bit per channel.
REQ-009 key_level  output  N_KEYS  debounced level per channel: 1 = released, 0 = pressed, independent of ACTIVE_LOW.
REQ-010 press_pulse  output  N_KEYS  one-cycle pulse on an accepted press.
REQ-011 release_pulse  output  N_KEYS  one-cycle pulse on an accepted release.
REQ-012 long_press  output  N_KEYS  one-cycle pulse, at most once per press.
REQ-013 key_state  output  2*N_KEYS  per-channel FSM state; channel i occupies bits [2i+1:2i].

Function
REQ-014 Each channel SHALL be fully independent; no shared counters or arbitration.
REQ-015 Input conditioning:
- key_in is inverted when ACTIVE_LOW=0.
- The result passes a 2-flop synchronizer.
- p = pressed, decoded from the second flop.
REQ-016 FSM encoding: IDLE=00, FILTER0=01, DOWN=11, FILTER1=10 (Gray; one bit changes per transition).
REQ-017 IDLE: p -> FILTER0 with cnt cleared; otherwise stay.
REQ-018 FILTER0:
- !p (bounce) -> IDLE, cnt cleared, no pulse.
- p and cnt==DEBOUNCE_CYCLES-1 -> DOWN, cnt cleared, press_pulse=1 for the next cycle.
- Otherwise cnt+1.
REQ-019 DOWN:
- !p -> FILTER1, cnt cleared.
- Otherwise cnt counts to LONG_PRESS_CYCLES-1 and saturates there.
- Reaching LONG_PRESS_CYCLES-1 with long_done=0 sets long_done and pulses long_press once.
REQ-020 FILTER1:
- p (bounce) -> DOWN, cnt cleared, long_done kept (no second long_press).
- !p and cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1 for the next cycle, long_done cleared.
- Otherwise cnt+1.
REQ-021 key_level SHALL decode the registered state: 1 in IDLE/FILTER0, 0 in DOWN/FILTER1; it changes in the same cycle as the state.
REQ-022 All pulses SHALL be registered; press_pulse and release_pulse coincide with the first cycle of the new state.
REQ-023 Latency: press_pulse is high after the (DEBOUNCE_CYCLES+2)th rising edge following the edge that first samples the pressed level; release latency is identical.
REQ-024 cnt width SHALL be $clog2(LONG_PRESS_CYCLES); counting never wraps.
REQ-025 Inputs whose stable runs are shorter than DEBOUNCE_CYCLES SHALL never produce a pulse or a key_level change.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=IDLE, cnt=0, long_done=0;
- synchronizer flops to the released value;
- key_level all 1, all pulses 0, key_state 0.
REQ-027 Reset asserted mid-press SHALL produce no release_pulse.
REQ-028 After rst_n rises, a key already held is accepted as a fresh press after the normal latency.

Structure
REQ-029 Package key_pkg SHALL hold the 2-bit state typedef and the four state constants.
REQ-030 The block SHALL contain sub-module key_debounce_ch (one channel: synchronizer, FSM, counter, pulse registers), instantiated N_KEYS times by a generate loop.

Verification (N_KEYS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1)
REQ-031 Clean press of key_in[0] to 0, held 8 cycles -> press_pulse[0] high for 1 cycle, 6 edges after the first sampling edge; key_level[0]=0; channel 1 unchanged.
REQ-032 Glitch of key_in[0] low for 3 cycles -> key_state[1:0] visits 01 then returns to 00; no pulse; key_level[0] stays 1.
REQ-033 Hold key_in[1] low 30 cycles, then release -> press_pulse[1], long_press[1] exactly once 10 cycles after entering DOWN, then release_pulse[1] 6 edges after release.
REQ-034 Release bounce: in DOWN after long_press, key high 2 cycles then low again -> state 11->10->11; no release_pulse and no second long_press.
REQ-035 Both keys pressed on the same edge -> both press_pulse bits high in the same cycle.
REQ-036 rst_n pulsed while key_in[0] held low in DOWN -> outputs return to reset values with no release_pulse; press_pulse[0] re-fires 6 edges after rst_n deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state type and helpers for the key debounce array
// Purpose: per-channel FSM state encoding (Gray order) and a level decoder.
// Ports: none (package).
package key_pkg;

  // Gray sequence IDLE -> FILTER0 -> DOWN -> FILTER1 -> IDLE flips one bit per step.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILTER0 = 2'b01,
    ST_DOWN    = 2'b11,
    ST_FILTER1 = 2'b10
  } key_state_t;

  // Debounced level: 1 = released (IDLE/FILTER0), 0 = pressed (DOWN/FILTER1).
  function automatic logic level_of(key_state_t s);
    return (s == ST_IDLE) || (s == ST_FILTER0);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one debounce channel: synchronizer, FSM, counter, pulses
// Purpose: filter a raw key pin into a stable level plus press/release/long-press pulses.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   key_in          raw key pin
//   key_level       debounced level (1 = released, 0 = pressed)
//   press_pulse     one-cycle pulse on accepted press
//   release_pulse   one-cycle pulse on accepted release
//   long_press      one-cycle pulse once per press after the long-press time
//   key_state       current FSM state
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 2500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [1:0] key_state
);

  localparam int CW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);

  // Conditioned pin is always active-low so the released value is 1.
  logic key_cond;
  assign key_cond = (ACTIVE_LOW != 0) ? key_in : ~key_in;

  logic sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_cond;
      sync2 <= sync1;
    end
  end

  logic p;
  assign p = ~sync2;

  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          long_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      long_done     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (p) begin
            state <= ST_FILTER0;
            cnt   <= '0;
          end
        end
        ST_FILTER0: begin
          if (!p) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= ST_DOWN;
            cnt         <= '0;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DOWN: begin
          if (!p) begin
            state <= ST_FILTER1;
            cnt   <= '0;
          end else if (cnt != LONG_LAST) begin
            cnt <= cnt + CW'(1);
          end else if (!long_done) begin
            // Counter parks at LONG_LAST; long_done keeps this to one pulse per press.
            long_done  <= 1'b1;
            long_press <= 1'b1;
          end
        end
        ST_FILTER1: begin
          if (p) begin
            // Release bounce: back to DOWN, long_done survives so no repeat long_press.
            state <= ST_DOWN;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            long_done     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign key_level = level_of(state);
  assign key_state = state;

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - array of independent key debounce channels
// Purpose: N_KEYS fully independent debounce channels, one per key pin.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   key_in          raw key pins, one bit per channel
//   key_level       debounced levels (1 = released, 0 = pressed)
//   press_pulse     per-channel accepted-press pulses
//   release_pulse   per-channel accepted-release pulses
//   long_press      per-channel long-press pulses
//   key_state       per-channel FSM state, channel i at [2i+1:2i]
module key_debounce_array #(
  parameter int N_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES   = 2500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_KEYS-1:0]     key_in,
  output logic [N_KEYS-1:0]     key_level,
  output logic [N_KEYS-1:0]     press_pulse,
  output logic [N_KEYS-1:0]     release_pulse,
  output logic [N_KEYS-1:0]     long_press,
  output logic [2*N_KEYS-1:0]   key_state
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .key_state    (key_state[2*i +: 2])
    );
  end

endmodule
